// File: rtl/pipe_stage_buf_if.sv
// Valid/ready payload channel between two pipeline stages.
// The master drives valid and data; the slave drives ready.
interface pipe_stage_buf_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic stage register: valid/ready handshake, optional skid entry, sync flush.
// Define PIPE_STAGE_PERF_EN to add stall/bubble/flush-drop counters.
module pipe_stage_buf #(
    parameter int DATA_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    pipe_stage_buf_if.slave   in_if,
    pipe_stage_buf_if.master  out_if
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_drop_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    logic              in_fire;
    logic              out_fire;
    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] main_data;

    // With the skid entry, ready depends only on stage state.
    assign in_if.ready = (SKID != 0) ? !skid_valid
                                     : (!main_valid | out_if.ready);

    assign in_fire  = in_if.valid & in_if.ready;
    assign out_fire = main_valid & out_if.ready;

    assign out_if.valid = main_valid;
    assign out_if.data  = main_data;

    generate
        if (SKID != 0) begin : g_skid
            state_t            state_q;
            state_t            state_d;
            logic              load_main;
            logic              load_skid;
            logic              move_skid;
            logic [DATA_W-1:0] skid_data;

            always_comb begin
                state_d   = state_q;
                load_main = 1'b0;
                load_skid = 1'b0;
                move_skid = 1'b0;
                if (flush) begin
                    state_d = EMPTY;
                end else begin
                    unique case (state_q)
                        EMPTY: begin
                            if (in_fire) begin
                                state_d   = ONE;
                                load_main = 1'b1;
                            end
                        end
                        ONE: begin
                            if (in_fire && out_fire) begin
                                load_main = 1'b1;
                            end else if (in_fire) begin
                                state_d   = TWO;
                                load_skid = 1'b1;
                            end else if (out_fire) begin
                                state_d = EMPTY;
                            end
                        end
                        TWO: begin
                            if (out_fire) begin
                                state_d   = ONE;
                                move_skid = 1'b1;
                            end
                        end
                        default: state_d = EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q   <= EMPTY;
                    main_data <= '0;
                    skid_data <= '0;
                end else begin
                    state_q <= state_d;
                    if (load_main) begin
                        main_data <= in_if.data;
                    end else if (move_skid) begin
                        main_data <= skid_data;
                    end
                    if (load_skid) begin
                        skid_data <= in_if.data;
                    end
                end
            end

            assign main_valid = (state_q != EMPTY);
            assign skid_valid = (state_q == TWO);
        end else begin : g_single
            logic valid_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_q   <= 1'b0;
                    main_data <= '0;
                end else begin
                    if (flush) begin
                        valid_q <= 1'b0;
                    end else if (in_fire) begin
                        valid_q <= 1'b1;
                    end else if (out_fire) begin
                        valid_q <= 1'b0;
                    end
                    if (in_fire && !flush) begin
                        main_data <= in_if.data;
                    end
                end
            end

            assign main_valid = valid_q;
            assign skid_valid = 1'b0;
        end
    endgenerate

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       drop_n;
    logic [CNT_W+1:0] drop_sum;

    // Held beats that did not leave this cycle, plus an accepted-then-squashed beat.
    assign drop_n = {1'b0, main_valid & ~out_fire}
                  + {1'b0, skid_valid}
                  + {1'b0, in_fire};
    assign drop_sum = {2'b00, flush_drop_cnt} + {{CNT_W{1'b0}}, drop_n};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt      <= '0;
            bubble_cnt     <= '0;
            flush_drop_cnt <= '0;
        end else begin
            if (main_valid && !out_if.ready && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (!main_valid && bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
            if (flush) begin
                if (drop_sum > {2'b00, CNT_MAX}) begin
                    flush_drop_cnt <= CNT_MAX;
                end else begin
                    flush_drop_cnt <= drop_sum[CNT_W-1:0];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf, one skid instance and one single-entry instance.
// Perf-counter checks build only when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_buf;

    logic clk;
    logic reset;
    logic flush1;
    logic flush0;
    int   checks;
    int   failures;

    pipe_stage_buf_if #(.DATA_W(8)) in1 ();
    pipe_stage_buf_if #(.DATA_W(8)) out1 ();
    pipe_stage_buf_if #(.DATA_W(8)) in0 ();
    pipe_stage_buf_if #(.DATA_W(8)) out0 ();

`ifdef PIPE_STAGE_PERF_EN
    logic [3:0] stall1, bubble1, drop1;
    logic [3:0] stall0, bubble0, drop0;
`endif

    pipe_stage_buf #(.DATA_W(8), .SKID(1), .CNT_W(4)) u1 (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush1),
        .in_if          (in1),
        .out_if         (out1)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt      (stall1),
        .bubble_cnt     (bubble1),
        .flush_drop_cnt (drop1)
`endif
    );

    pipe_stage_buf #(.DATA_W(8), .SKID(0), .CNT_W(4)) u0 (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush0),
        .in_if          (in0),
        .out_if         (out0)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt      (stall0),
        .bubble_cnt     (bubble0),
        .flush_drop_cnt (drop0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if (out1.valid !== 1'b0 || in1.ready !== 1'b1 || out1.data !== 8'h00) begin
            failures++;
            $display("FAIL reset_skid1 got v=%b r=%b d=%h exp v=0 r=1 d=00",
                     out1.valid, in1.ready, out1.data);
        end
        checks++;
        if (out0.valid !== 1'b0 || in0.ready !== 1'b1 || out0.data !== 8'h00) begin
            failures++;
            $display("FAIL reset_skid0 got v=%b r=%b d=%h exp v=0 r=1 d=00",
                     out0.valid, in0.ready, out0.data);
        end
`ifdef PIPE_STAGE_PERF_EN
        checks++;
        if (stall1 !== 4'd0 || bubble1 !== 4'd0 || drop1 !== 4'd0) begin
            failures++;
            $display("FAIL reset_perf got %0d/%0d/%0d exp 0/0/0",
                     stall1, bubble1, drop1);
        end
`endif
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        out1.ready = 1'b0;
        in1.valid  = 1'b1;
        in1.data   = 8'h50;
        step();
        in1.data = 8'h51;
        step();
        in1.valid = 1'b0;
        checks++;
        if (in1.ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_two got ready=%b exp 0", in1.ready);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out1.valid !== 1'b0 || in1.ready !== 1'b1 || out1.data !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_async got v=%b r=%b d=%h exp v=0 r=1 d=00",
                     out1.valid, in1.ready, out1.data);
        end
        step();
        reset = 1'b0;
        in1.valid = 1'b1;
        in1.data  = 8'hA5;
        step();
        in1.valid = 1'b0;
        checks++;
        if (out1.valid !== 1'b1 || out1.data !== 8'hA5) begin
            failures++;
            $display("FAIL reset_mid_push got v=%b d=%h exp v=1 d=a5",
                     out1.valid, out1.data);
        end
        out1.ready = 1'b1;
        step();
        checks++;
        if (out1.valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_drain got v=%b exp 0", out1.valid);
        end
    endtask

    task automatic test_stream();
        out1.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in1.valid = 1'b1;
            in1.data  = 8'(i);
            #1;
            checks++;
            if (in1.ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_ready beat=%0d got %b exp 1", i, in1.ready);
            end
            step();
            checks++;
            if (out1.valid !== 1'b1 || out1.data !== 8'(i)) begin
                failures++;
                $display("FAIL stream_out beat=%0d got v=%b d=%h exp v=1 d=%h",
                         i, out1.valid, out1.data, 8'(i));
            end
        end
        in1.valid = 1'b0;
        step();
        checks++;
        if (out1.valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_end got v=%b exp 0", out1.valid);
        end
    endtask

    task automatic test_backpressure();
        out1.ready = 1'b0;
        in1.valid  = 1'b1;
        in1.data   = 8'h10;
        step();
        in1.data = 8'h11;
        step();
        in1.data = 8'h12;
        checks++;
        if (in1.ready !== 1'b0 || out1.data !== 8'h10) begin
            failures++;
            $display("FAIL bp_two got r=%b d=%h exp r=0 d=10", in1.ready, out1.data);
        end
        step();
        checks++;
        if (in1.ready !== 1'b0 || out1.valid !== 1'b1 || out1.data !== 8'h10) begin
            failures++;
            $display("FAIL bp_hold got r=%b v=%b d=%h exp r=0 v=1 d=10",
                     in1.ready, out1.valid, out1.data);
        end
        out1.ready = 1'b1;
        step();
        checks++;
        if (out1.data !== 8'h11 || in1.ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_second got d=%h r=%b exp d=11 r=1", out1.data, in1.ready);
        end
        step();
        in1.valid = 1'b0;
        checks++;
        if (out1.valid !== 1'b1 || out1.data !== 8'h12) begin
            failures++;
            $display("FAIL bp_third got v=%b d=%h exp v=1 d=12", out1.valid, out1.data);
        end
        step();
        checks++;
        if (out1.valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got v=%b exp 0", out1.valid);
        end
    endtask

    task automatic test_flush();
        out1.ready = 1'b0;
        in1.valid  = 1'b1;
        in1.data   = 8'h20;
        step();
        in1.valid = 1'b0;
        flush1    = 1'b1;
        step();
        flush1 = 1'b0;
        checks++;
        if (out1.valid !== 1'b0 || in1.ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_one got v=%b r=%b exp v=0 r=1", out1.valid, in1.ready);
        end
`ifdef PIPE_STAGE_PERF_EN
        checks++;
        if (drop1 !== 4'd1) begin
            failures++;
            $display("FAIL flush_one_cnt got %0d exp 1", drop1);
        end
`endif
        in1.valid = 1'b1;
        in1.data  = 8'h30;
        step();
        in1.data = 8'h31;
        step();
        in1.data = 8'h33;
        flush1   = 1'b1;
        step();
        flush1    = 1'b0;
        in1.valid = 1'b0;
        checks++;
        if (out1.valid !== 1'b0 || in1.ready !== 1'b1 || out1.data !== 8'h30) begin
            failures++;
            $display("FAIL flush_two got v=%b r=%b d=%h exp v=0 r=1 d=30",
                     out1.valid, in1.ready, out1.data);
        end
`ifdef PIPE_STAGE_PERF_EN
        checks++;
        if (drop1 !== 4'd3) begin
            failures++;
            $display("FAIL flush_two_cnt got %0d exp 3", drop1);
        end
`endif
        out1.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out1.valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_ghost cyc=%0d got v=%b d=%h exp v=0",
                         i, out1.valid, out1.data);
            end
        end
    endtask

    task automatic test_skid0();
        logic       pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       mv;
        logic       exp_rdy;
        logic [7:0] nxt;
        logic [7:0] q [$];
        mv  = 1'b0;
        nxt = 8'h40;
        for (int i = 0; i < 12; i++) begin
            in0.valid  = (i < 8);
            in0.data   = nxt;
            out0.ready = (i < 8) ? pat[i] : 1'b1;
            #1;
            exp_rdy = !mv | out0.ready;
            checks++;
            if (in0.ready !== exp_rdy) begin
                failures++;
                $display("FAIL skid0_ready cyc=%0d got %b exp %b", i, in0.ready, exp_rdy);
            end
            if (mv && out0.ready) begin
                checks++;
                if (out0.valid !== 1'b1 || out0.data !== q[0]) begin
                    failures++;
                    $display("FAIL skid0_data cyc=%0d got v=%b d=%h exp v=1 d=%h",
                             i, out0.valid, out0.data, q[0]);
                end
                void'(q.pop_front());
            end
            if (in0.valid && exp_rdy) begin
                q.push_back(nxt);
                nxt = nxt + 8'h01;
                mv  = 1'b1;
            end else if (mv && out0.ready) begin
                mv = 1'b0;
            end
            step();
        end
        in0.valid = 1'b0;
        checks++;
        if (out0.valid !== 1'b0 || q.size() != 0) begin
            failures++;
            $display("FAIL skid0_drain got v=%b left=%0d exp v=0 left=0",
                     out0.valid, q.size());
        end
        out0.ready = 1'b0;
        in0.valid  = 1'b1;
        in0.data   = 8'h60;
        step();
        in0.data = 8'h61;
        flush0   = 1'b1;
        step();
        flush0    = 1'b0;
        in0.valid = 1'b0;
        checks++;
        if (out0.valid !== 1'b0 || in0.ready !== 1'b1 || out0.data !== 8'h60) begin
            failures++;
            $display("FAIL skid0_flush got v=%b r=%b d=%h exp v=0 r=1 d=60",
                     out0.valid, in0.ready, out0.data);
        end
`ifdef PIPE_STAGE_PERF_EN
        checks++;
        if (drop0 !== 4'd1) begin
            failures++;
            $display("FAIL skid0_flush_cnt got %0d exp 1", drop0);
        end
`endif
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_stall_cnt();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        out1.ready = 1'b0;
        in1.valid  = 1'b1;
        in1.data   = 8'h77;
        step();
        in1.valid = 1'b0;
        checks++;
        if (stall1 !== 4'd0 || bubble1 !== 4'd1) begin
            failures++;
            $display("FAIL perf_first got s=%0d b=%0d exp s=0 b=1", stall1, bubble1);
        end
        repeat (3) step();
        checks++;
        if (stall1 !== 4'd3) begin
            failures++;
            $display("FAIL perf_stall3 got %0d exp 3", stall1);
        end
        repeat (20) step();
        checks++;
        if (stall1 !== 4'd15 || bubble1 !== 4'd1 || out1.data !== 8'h77) begin
            failures++;
            $display("FAIL perf_sat got s=%0d b=%0d d=%h exp s=15 b=1 d=77",
                     stall1, bubble1, out1.data);
        end
        out1.ready = 1'b1;
        step();
    endtask
`endif

    initial begin
        checks     = 0;
        failures   = 0;
        flush1     = 1'b0;
        flush0     = 1'b0;
        in1.valid  = 1'b0;
        in1.data   = 8'h00;
        out1.ready = 1'b0;
        in0.valid  = 1'b0;
        in0.data   = 8'h00;
        out0.ready = 1'b0;
        test_reset();
        test_reset_mid();
        test_stream();
        test_backpressure();
        test_flush();
        test_skid0();
`ifdef PIPE_STAGE_PERF_EN
        test_stall_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
